vga_timing_ctrl: RTL and testbench
==================================

Name: vga_timing_ctrl

Overview:
- Sequences the VGA raster as two phase state machines, horizontal and vertical: ACTIVE, FRONT, SYNC, BACK.
- Produces registered hsync/vsync with the porches built in, plus col/row counters and an active-video flag.
- Issues a per-line fetch request to the upstream pixel source using a req/ack handshake.
- Sits between the pattern/framebuffer source and the colour output registers, and replaces ad-hoc porch masking downstream.

Parameters:
- CNT_WIDTH, 10, width of the col/row counters.
- H_ACTIVE, 640, visible columns.
- H_FRONT, 18, horizontal front porch in clocks.
- H_SYNC, 92, hsync pulse width in clocks.
- H_BACK, 50, horizontal back porch in clocks (line total 800).
- V_ACTIVE, 480, visible rows.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch in lines (frame total 525).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- i_enable  in  1  run request, level-sensitive.
- o_hsync  out  1  horizontal sync, active low.
- o_vsync  out  1  vertical sync, active low.
- o_active  out  1  high while both axes are in ACTIVE.
- o_col  out  CNT_WIDTH  current column, 0..799.
- o_row  out  CNT_WIDTH  current row, 0..524.
- o_frame_start  out  1  one-cycle pulse at col 0, row 0.
- o_line_req  out  1  request to prefetch the next active line.
- i_line_ack  in  1  source acknowledges the line request.
- o_running  out  1  high while the raster is being generated.

Behaviour:
- Reset (async, rst=1): both FSMs to IDLE; o_col=0, o_row=0; o_hsync=1, o_vsync=1; all other outputs 0.
- All outputs are registered and mutually consistent in the same cycle; there is no extra pipeline delay.
- Horizontal column ranges: ACTIVE 0..639, FRONT 640..657, SYNC 658..749, BACK 750..799. o_hsync=0 only in SYNC.
- At col 799, col wraps to 0 and the vertical axis advances one line.
- Vertical row ranges: ACTIVE 0..479, FRONT 480..489, SYNC 490..491, BACK 492..524. o_vsync=0 only in SYNC.
- Vertical state changes only on the horizontal wrap cycle. Row 524 wraps to 0.
- Range boundaries derive from the parameters (sums of preceding phases); nothing is hard-coded.
- Counter increments are CNT_WIDTH unsigned; compare against TOTAL-1 for the wrap, never rely on overflow.
- Start: in IDLE with i_enable=1, the next cycle enters ACTIVE/ACTIVE at col 0, row 0. That cycle has o_frame_start=1 and o_running=1.
- Stop: i_enable=0 mid-frame is recorded. The frame completes, then at col 799, row 524 both FSMs return to IDLE and outputs take their reset values.
- If i_enable returns to 1 before the frame end, the stop is cancelled and there is no gap.
- o_frame_start pulses on every entry to col 0, row 0.
- Line request:
  - o_line_req rises on the cycle col becomes 750 (BACK entry) if the next row is active, i.e. row <= 478 or row == 524.
  - It is held until i_line_ack is sampled high while req=1, then falls on the next cycle.
  - i_line_ack while req=0 is ignored.
  - If req is still high when col wraps to 0, req is dropped (a missed line).
- A stop or reset mid-handshake clears o_line_req.

Optional Feature:
- Macro: VGA_TIMING_STATUS_EN.
- Defined: adds output o_underrun (1 bit) and o_frame_count (16 bit), both reset to 0.
  - o_underrun is a sticky flag set on a missed line, cleared only by rst.
  - o_frame_count increments on each o_frame_start and wraps at 65535 to 0.
- Undefined: neither port exists; missed lines are silently dropped.

Decomposition:
- Package vga_timing_pkg holds:
  - phase encoding: IDLE=0, ACTIVE=1, FRONT=2, SYNC=3, BACK=4, 3 bits;
  - default 640x480 timing constants.
- Sub-module vga_axis_fsm (counter plus phase FSM with advance/wrap inputs) is instantiated twice, for horizontal and vertical.

Test Plan:
- Reset then i_enable=1: o_frame_start=1 at the first cycle; o_hsync=0 for exactly 92 clocks beginning col 658; line period 800 clocks.
- Full frame: o_vsync low for rows 490..491 (1600 clocks); o_active high for 640x480 = 307200 cycles per 420000-cycle frame.
- Handshake: ack 3 cycles after o_line_req rises at col 750, row 10 -> req falls the cycle after ack; no req at row 479 BACK; req at row 524.
- Missed line: never ack at row 5 -> req drops at col 0, row 6; with VGA_TIMING_STATUS_EN, o_underrun=1 and stays 1.
- Stop: i_enable=0 at row 200 -> raster continues to col 799, row 524, then o_running=0 and o_hsync=o_vsync=1. Re-enable at row 300 instead -> no interruption.
- Async reset at col 700, row 490 -> outputs reach reset values immediately; o_line_req=0, o_vsync=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared phase encoding and default 640x480@60 timing for the VGA raster controller.
package vga_timing_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACTIVE = 3'd1,
    FRONT  = 3'd2,
    SYNC   = 3'd3,
    BACK   = 3'd4
  } phase_e;

  localparam int unsigned DEF_CNT_WIDTH = 10;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 18;
  localparam int unsigned DEF_H_SYNC   = 92;
  localparam int unsigned DEF_H_BACK   = 50;

  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;

  localparam int unsigned FRAME_CNT_WIDTH = 16;

endpackage

// File: rtl/vga_axis_fsm.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Next-state values are exported so the parent can register outputs without extra latency.
module vga_axis_fsm
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int unsigned ACT_LEN   = DEF_H_ACTIVE,
  parameter int unsigned FRONT_LEN = DEF_H_FRONT,
  parameter int unsigned SYNC_LEN  = DEF_H_SYNC,
  parameter int unsigned BACK_LEN  = DEF_H_BACK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 advance,
  output phase_e               state_nxt_c,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic [CNT_WIDTH-1:0] cnt_nxt_c,
  output logic                 wrap_c
);

  localparam int unsigned FRONT_START = ACT_LEN;
  localparam int unsigned SYNC_START  = FRONT_START + FRONT_LEN;
  localparam int unsigned BACK_START  = SYNC_START + SYNC_LEN;
  localparam int unsigned TOTAL       = BACK_START + BACK_LEN;

  phase_e               state;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 at_last;

  assign cnt_inc = cnt + CNT_WIDTH'(1);
  assign at_last = (cnt == CNT_WIDTH'(TOTAL - 1));
  // Kept independent of clear so the parent can derive clear from the wrap.
  assign wrap_c  = (state != IDLE) && advance && at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt_c;
      cnt   <= cnt_nxt_c;
    end
  end

  always_comb begin
    state_nxt_c = state;
    cnt_nxt_c   = cnt;
    if (clear) begin
      state_nxt_c = IDLE;
      cnt_nxt_c   = '0;
    end else if (state == IDLE) begin
      if (start) begin
        state_nxt_c = ACTIVE;
        cnt_nxt_c   = '0;
      end
    end else if (advance) begin
      if (at_last) begin
        state_nxt_c = ACTIVE;
        cnt_nxt_c   = '0;
      end else begin
        cnt_nxt_c = cnt_inc;
        if (cnt_inc == CNT_WIDTH'(FRONT_START)) begin
          state_nxt_c = FRONT;
        end else if (cnt_inc == CNT_WIDTH'(SYNC_START)) begin
          state_nxt_c = SYNC;
        end else if (cnt_inc == CNT_WIDTH'(BACK_START)) begin
          state_nxt_c = BACK;
        end
      end
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing controller: syncs, counters, active flag and per-line prefetch handshake.
// Optional status outputs (underrun flag, frame counter) when VGA_TIMING_STATUS_EN is defined.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  output logic                 o_hsync,
  output logic                 o_vsync,
  output logic                 o_active,
  output logic [CNT_WIDTH-1:0] o_col,
  output logic [CNT_WIDTH-1:0] o_row,
  output logic                 o_frame_start,
  output logic                 o_line_req,
  input  logic                 i_line_ack,
  output logic                 o_running
`ifdef VGA_TIMING_STATUS_EN
  ,
  output logic                       o_underrun,
  output logic [FRAME_CNT_WIDTH-1:0] o_frame_count
`endif
);

  localparam int unsigned H_BACK_START = H_ACTIVE + H_FRONT + H_SYNC;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  phase_e               h_state_nxt, v_state_nxt;
  logic [CNT_WIDTH-1:0] h_cnt_nxt, v_cnt_nxt;
  logic                 h_wrap, v_wrap;
  logic                 start_c, clear_c, running_nxt;
  logic                 back_entry_c, next_row_active_c, req_nxt;

  assign start_c     = !o_running && i_enable;
  // A stop takes effect only at the last pixel of the frame; re-enabling before then cancels it.
  assign clear_c     = h_wrap && v_wrap && !i_enable;
  assign running_nxt = (h_state_nxt != IDLE);

  vga_axis_fsm #(
    .CNT_WIDTH (CNT_WIDTH),
    .ACT_LEN   (H_ACTIVE),
    .FRONT_LEN (H_FRONT),
    .SYNC_LEN  (H_SYNC),
    .BACK_LEN  (H_BACK)
  ) u_h_axis (
    .clk         (clk),
    .rst         (rst),
    .start       (start_c),
    .clear       (clear_c),
    .advance     (1'b1),
    .state_nxt_c (h_state_nxt),
    .cnt         (o_col),
    .cnt_nxt_c   (h_cnt_nxt),
    .wrap_c      (h_wrap)
  );

  vga_axis_fsm #(
    .CNT_WIDTH (CNT_WIDTH),
    .ACT_LEN   (V_ACTIVE),
    .FRONT_LEN (V_FRONT),
    .SYNC_LEN  (V_SYNC),
    .BACK_LEN  (V_BACK)
  ) u_v_axis (
    .clk         (clk),
    .rst         (rst),
    .start       (start_c),
    .clear       (clear_c),
    .advance     (h_wrap),
    .state_nxt_c (v_state_nxt),
    .cnt         (o_row),
    .cnt_nxt_c   (v_cnt_nxt),
    .wrap_c      (v_wrap)
  );

  // The row about to follow is visible: rows up to V_ACTIVE-2, or the last row before wrap.
  assign next_row_active_c = (o_row < CNT_WIDTH'(V_ACTIVE - 1)) ||
                             (o_row == CNT_WIDTH'(V_TOTAL - 1));
  assign back_entry_c      = (h_state_nxt == BACK) && (h_cnt_nxt == CNT_WIDTH'(H_BACK_START));

  always_comb begin
    req_nxt = o_line_req;
    if (!running_nxt) begin
      req_nxt = 1'b0;
    end else if (o_line_req && i_line_ack) begin
      req_nxt = 1'b0;
    end else if (o_line_req && h_wrap) begin
      req_nxt = 1'b0;
    end else if (back_entry_c && next_row_active_c) begin
      req_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_hsync       <= 1'b1;
      o_vsync       <= 1'b1;
      o_active      <= 1'b0;
      o_frame_start <= 1'b0;
      o_line_req    <= 1'b0;
      o_running     <= 1'b0;
    end else begin
      o_hsync       <= (h_state_nxt != SYNC);
      o_vsync       <= (v_state_nxt != SYNC);
      o_active      <= (h_state_nxt == ACTIVE) && (v_state_nxt == ACTIVE);
      o_frame_start <= running_nxt && (h_cnt_nxt == '0) && (v_cnt_nxt == '0);
      o_line_req    <= req_nxt;
      o_running     <= running_nxt;
    end
  end

`ifdef VGA_TIMING_STATUS_EN
  logic missed_c;

  // Request still outstanding when the line it was for begins.
  assign missed_c = o_line_req && !i_line_ack && h_wrap && running_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_underrun    <= 1'b0;
      o_frame_count <= '0;
    end else begin
      o_underrun <= o_underrun || missed_c;
      if (o_frame_start) begin
        o_frame_count <= o_frame_count + FRAME_CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl using a reduced raster (28x13) and a position-based model.
module tb_vga_timing_ctrl;

  localparam int unsigned W  = 10;
  localparam int HA = 16, HF = 2, HS = 4, HB = 6;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_enable;
  logic         i_line_ack;
  logic         o_hsync, o_vsync, o_active, o_frame_start, o_line_req, o_running;
  logic [W-1:0] o_col, o_row;
`ifdef VGA_TIMING_STATUS_EN
  logic         o_underrun;
  logic [15:0]  o_frame_count;
`endif

  vga_timing_ctrl #(
    .CNT_WIDTH (W),
    .H_ACTIVE  (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_ACTIVE  (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (i_enable),
    .o_hsync       (o_hsync),
    .o_vsync       (o_vsync),
    .o_active      (o_active),
    .o_col         (o_col),
    .o_row         (o_row),
    .o_frame_start (o_frame_start),
    .o_line_req    (o_line_req),
    .i_line_ack    (i_line_ack),
    .o_running     (o_running)
`ifdef VGA_TIMING_STATUS_EN
    ,
    .o_underrun    (o_underrun),
    .o_frame_count (o_frame_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: raster position since start of frame, plus handshake/status state.
  bit m_run, m_req, m_fs, m_under;
  int m_pos, m_fc;

  task automatic model_reset();
    m_run = 0; m_req = 0; m_fs = 0; m_under = 0; m_pos = 0; m_fc = 0;
  endtask

  task automatic model_step(input bit en, input bit ack);
    bit was_req;
    int col, row;
    was_req = m_req;
    if (m_fs) m_fc = (m_fc + 1) % 65536;
    if (!m_run) begin
      if (en) begin m_run = 1; m_pos = 0; end
    end else if (m_pos == FRAME - 1) begin
      m_pos = 0;
      if (!en) m_run = 0;
    end else begin
      m_pos = m_pos + 1;
    end
    col = m_pos % HT;
    row = m_pos / HT;
    if (!m_run) m_req = 0;
    else if (was_req && ack) m_req = 0;
    else if (was_req && col == 0) begin m_req = 0; m_under = 1; end
    else if (col == HA + HF + HS && (row <= VA - 2 || row == VT - 1)) m_req = 1;
    m_fs = m_run && (m_pos == 0);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int col, row;
    logic [2*W+5:0] exp_v, got_v;
    col = m_pos % HT;
    row = m_pos / HT;
    exp_v = {!(m_run && col >= HA + HF && col < HA + HF + HS),
             !(m_run && row >= VA + VF && row < VA + VF + VS),
             1'(m_run && col < HA && row < VA),
             1'(m_fs), 1'(m_req), 1'(m_run), W'(col), W'(row)};
    got_v = {o_hsync, o_vsync, o_active, o_frame_start, o_line_req, o_running, o_col, o_row};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL cycle pos=%0d got=%h exp=%h (hs vs act fs req run col row)", m_pos, got_v, exp_v);
    end
`ifdef VGA_TIMING_STATUS_EN
    chk("underrun", int'(o_underrun), int'(m_under));
    chk("frame_count", int'(o_frame_count), m_fc);
`endif
  endtask

  task automatic tick(input bit en, input bit ack);
    i_enable   = en;
    i_line_ack = ack;
    @(posedge clk);
    model_step(en, ack);
    #1;
    check_outputs();
  endtask

  task automatic goto_pos(input int row, input int col);
    int n;
    n = 0;
    while (m_pos != row * HT + col && n < 2 * FRAME) begin
      tick(1'b1, 1'b0);
      n++;
    end
    chk("goto_reached", m_pos, row * HT + col);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit en;
    int cycles;
    int col;
    int row;
    bit run;
    bit hs;
    bit vs;
  } vec_t;

  vec_t tbl[14];
  int hs_low, vs_low, act_cnt, fs_cnt;

  initial begin
    tbl[0]  = '{1'b1,   1,  0,  0, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{1'b1,  17, 17,  0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b1,   1, 18,  0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1,   4, 22,  0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b1,   6,  0,  1, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 196,  0,  8, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0,  10, 10,  8, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 129, 27, 12, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0,   1,  0,  0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0,   5,  0,  0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b1,   1,  0,  0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b0,  56,  0,  2, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 308,  0,  0, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b1,   1,  1,  0, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; i_enable = 1'b0; i_line_ack = 1'b0;
    model_reset();
    #12;
    chk("rst_col", int'(o_col), 0);
    chk("rst_row", int'(o_row), 0);
    chk("rst_hsync", int'(o_hsync), 1);
    chk("rst_vsync", int'(o_vsync), 1);
    chk("rst_running", int'(o_running), 0);
    chk("rst_line_req", int'(o_line_req), 0);
    chk("rst_frame_start", int'(o_frame_start), 0);
    chk("rst_active", int'(o_active), 0);
    rst = 1'b0;

    // Start, phase boundaries, stop at frame end, idle, restart and cancelled stop.
    for (int i = 0; i < 14; i++) begin
      repeat (tbl[i].cycles) tick(tbl[i].en, 1'b0);
      checks++;
      if ({int'(o_col), int'(o_row), o_running, o_hsync, o_vsync} !==
          {tbl[i].col, tbl[i].row, tbl[i].run, tbl[i].hs, tbl[i].vs}) begin
        errors++;
        $display("FAIL vec%0d got col=%0d row=%0d run=%0b hs=%0b vs=%0b exp col=%0d row=%0d run=%0b hs=%0b vs=%0b",
                 i, o_col, o_row, o_running, o_hsync, o_vsync,
                 tbl[i].col, tbl[i].row, tbl[i].run, tbl[i].hs, tbl[i].vs);
      end
    end

    // One whole frame: per-frame totals of sync, active and frame-start cycles.
    hs_low = 0; vs_low = 0; act_cnt = 0; fs_cnt = 0;
    repeat (FRAME) begin
      tick(1'b1, 1'b0);
      hs_low  += int'(!o_hsync);
      vs_low  += int'(!o_vsync);
      act_cnt += int'(o_active);
      fs_cnt  += int'(o_frame_start);
    end
    chk("frame_hsync_low", hs_low, HS * VT);
    chk("frame_vsync_low", vs_low, VS * HT);
    chk("frame_active", act_cnt, HA * VA);
    chk("frame_starts", fs_cnt, 1);

    // Handshake: ack three cycles after the request rises.
    pulse_reset();
    tick(1'b1, 1'b0);
    chk("start_frame_start", int'(o_frame_start), 1);
    goto_pos(0, 21);
    tick(1'b1, 1'b0);
    chk("req_rise", int'(o_line_req), 1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("req_held", int'(o_line_req), 1);
    tick(1'b1, 1'b1);
    chk("req_fall_after_ack", int'(o_line_req), 0);
`ifdef VGA_TIMING_STATUS_EN
    chk("no_underrun_yet", int'(o_underrun), 0);
`endif
    // Missed line: never acknowledged, dropped at the next line start.
    goto_pos(1, 22);
    chk("req_row1", int'(o_line_req), 1);
    goto_pos(2, 0);
    chk("req_missed_drop", int'(o_line_req), 0);
`ifdef VGA_TIMING_STATUS_EN
    chk("underrun_set", int'(o_underrun), 1);
`endif
    goto_pos(VA - 1, HA + HF + HS);
    chk("no_req_last_active", int'(o_line_req), 0);
    goto_pos(VT - 1, HA + HF + HS);
    chk("req_last_row", int'(o_line_req), 1);
    tick(1'b1, 1'b1);
    chk("req_last_row_ack", int'(o_line_req), 0);

    // Async reset in the middle of vsync and hsync.
    goto_pos(VA + VF, HA + HF + 2);
    chk("pre_rst_vsync", int'(o_vsync), 0);
    rst = 1'b1;
    #1;
    chk("arst_col", int'(o_col), 0);
    chk("arst_row", int'(o_row), 0);
    chk("arst_vsync", int'(o_vsync), 1);
    chk("arst_hsync", int'(o_hsync), 1);
    chk("arst_line_req", int'(o_line_req), 0);
    chk("arst_running", int'(o_running), 0);
`ifdef VGA_TIMING_STATUS_EN
    chk("arst_underrun", int'(o_underrun), 0);
`endif
    model_reset();
    #1;
    rst = 1'b0;

    // Randomised run against the model.
    for (int i = 0; i < 3000; i++) begin
      tick(1'($urandom_range(0, 99) < 97), 1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
